// File: rtl/de0_lt24_sopc_cpu_oci_dct_packer_pkg.sv
// Shared constants and types for the OCI direct-control-transfer trace packer.
//   DCT_CODE_W  : width of one trace code
//   DCT_BUF_W   : accumulation buffer width (15 codes x 2 bits)
//   DCT_CNT_W   : code-count width
//   DCT_FRAME_W : emitted frame width, {count, buffer}
//   dct_state_e : packer control state
package de0_lt24_sopc_cpu_oci_dct_pkg;
  localparam int DCT_CODE_W  = 2;
  localparam int DCT_BUF_W   = 30;
  localparam int DCT_CNT_W   = 4;
  localparam int DCT_FRAME_W = 34;

  typedef enum logic {
    ACCUM     = 1'b0,
    FULL_WAIT = 1'b1
  } dct_state_e;
endpackage

// File: rtl/de0_lt24_sopc_cpu_oci_dct_packer_frame_reg.sv
// One-entry valid/ready holding register for emitted frames.
//   clk, reset  : clock, async active-high reset
//   load        : capture load_data this edge (only issued when slot_free)
//   load_data   : frame to capture
//   frame_ready : consumer accepts the held frame
//   frame_valid : a frame is held
//   frame_data  : held frame
//   slot_free   : the register can take a new frame on this edge
module de0_lt24_sopc_cpu_oci_dct_frame_reg
  import de0_lt24_sopc_cpu_oci_dct_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [DCT_FRAME_W-1:0] load_data,
  input  logic                   frame_ready,
  output logic                   frame_valid,
  output logic [DCT_FRAME_W-1:0] frame_data,
  output logic                   slot_free
);
  // Free when empty, or when the held frame leaves on this same edge.
  assign slot_free = !frame_valid || frame_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
    end else if (load) begin
      frame_valid <= 1'b1;
      frame_data  <= load_data;
    end else if (frame_ready) begin
      frame_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/de0_lt24_sopc_cpu_oci_dct_packer.sv
// Packs 2-bit DCT trace codes into frames of up to MAX_CODES codes.
//   clk, reset   : clock, async active-high reset
//   dct_code     : trace code, accepted when dct_valid is high
//   flush        : emit the partial buffer (latched if the slot is busy)
//   dct_buffer   : live buffer, newest code in bits [1:0]
//   dct_count    : codes held in dct_buffer
//   frame_valid/frame_ready/frame_data : frame output handshake
//   overflow     : sticky, a code was dropped while full and blocked
//   idle         : nothing buffered, pending or presented
module de0_lt24_sopc_cpu_oci_dct_packer
  import de0_lt24_sopc_cpu_oci_dct_pkg::*;
#(
  parameter int MAX_CODES = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DCT_CODE_W-1:0]  dct_code,
  input  logic                   dct_valid,
  input  logic                   flush,
  output logic [DCT_BUF_W-1:0]   dct_buffer,
  output logic [DCT_CNT_W-1:0]   dct_count,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [DCT_FRAME_W-1:0] frame_data,
  output logic                   overflow,
  output logic                   idle
);
  localparam logic [DCT_CNT_W-1:0] MAX_CNT = DCT_CNT_W'(MAX_CODES);

  dct_state_e             state_q, state_d;
  logic [DCT_BUF_W-1:0]   buf_q, buf_d;
  logic [DCT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   fp_q, fp_d;
  logic                   slot_free, do_xfer, drop;
  logic [DCT_FRAME_W-1:0] xfer_data;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ACCUM;
    else       state_q <= state_d;
  end

  // Next state: only a full buffer blocked by a busy slot waits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:     if (!do_xfer && cnt_d == MAX_CNT) state_d = FULL_WAIT;
      FULL_WAIT: if (slot_free) state_d = ACCUM;
      default:   state_d = ACCUM;
    endcase
  end

  // Control outputs and accumulator next values
  always_comb begin
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    fp_d      = fp_q;
    do_xfer   = 1'b0;
    xfer_data = '0;
    drop      = 1'b0;
    case (state_q)
      ACCUM: begin
        if (dct_valid) begin
          buf_d = {buf_q[DCT_BUF_W-DCT_CODE_W-1:0], dct_code};
          cnt_d = cnt_q + 4'd1;
        end
        // A code arriving with the flush belongs to the flushed frame.
        if (slot_free && (cnt_d == MAX_CNT || ((flush || fp_q) && cnt_d != '0))) begin
          do_xfer   = 1'b1;
          xfer_data = {cnt_d, buf_d};
          buf_d     = '0;
          cnt_d     = '0;
          fp_d      = 1'b0;
        end else if (flush && cnt_d != '0) begin
          fp_d = 1'b1;
        end
      end
      FULL_WAIT: begin
        if (slot_free) begin
          // The full frame leaves; a same-cycle code starts the next buffer.
          do_xfer   = 1'b1;
          xfer_data = {cnt_q, buf_q};
          buf_d     = dct_valid ? DCT_BUF_W'(dct_code) : '0;
          cnt_d     = DCT_CNT_W'(dct_valid);
          fp_d      = flush && dct_valid;
        end else begin
          drop = dct_valid;
          if (flush) fp_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q    <= '0;
      cnt_q    <= '0;
      fp_q     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      fp_q  <= fp_d;
      if (drop) overflow <= 1'b1;
    end
  end

  de0_lt24_sopc_cpu_oci_dct_frame_reg u_frame_reg (
    .clk         (clk),
    .reset       (reset),
    .load        (do_xfer),
    .load_data   (xfer_data),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .slot_free   (slot_free)
  );

  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;
  assign idle       = (cnt_q == '0) && !fp_q && !frame_valid;
endmodule
